// File: rtl/rng_range_sampler.sv
// Draws a uniform value in [0, limit-1] from a free-running random word by
// masked rejection sampling, falling back to a modular fold after MAX_TRIES draws.
module rng_range_sampler #(
    parameter int RNG_BITS  = 11,
    parameter int OUT_W     = 4,
    parameter int MAX_TRIES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RNG_BITS-1:0] rng_data,
    input  logic                req,
    input  logic [OUT_W-1:0]    limit,
    output logic [OUT_W-1:0]    value,
    output logic                valid,
    input  logic                ack,
    output logic                busy,
    output logic                err,
    output logic                fallback,
    output logic [7:0]          tries
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] lim_q, mask_q;
    logic [OUT_W-1:0] mask_d, m;
    logic [7:0]       tries_inc;
    logic             hit, give_up;

    // Smear the top set bit of (limit-1) downward: smallest 2^k-1 covering it.
    always_comb begin
        mask_d = limit - OUT_W'(1);
        for (int i = 1; i < OUT_W; i++)
            mask_d = mask_d | (mask_d >> i);
    end

    assign m         = rng_data[OUT_W-1:0] & mask_q;
    assign tries_inc = (tries >= 8'(MAX_TRIES)) ? tries : tries + 8'd1;
    assign hit       = (m < lim_q);
    assign give_up   = (tries_inc >= 8'(MAX_TRIES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req) state_d = (limit == '0) ? DONE : DRAW;
            DRAW: if (hit || give_up) state_d = DONE;
            DONE: if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value    <= '0;
            err      <= 1'b0;
            fallback <= 1'b0;
            tries    <= '0;
            lim_q    <= '0;
            mask_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    lim_q    <= limit;
                    mask_q   <= mask_d;
                    tries    <= '0;
                    fallback <= 1'b0;
                    err      <= (limit == '0);
                    if (limit == '0) value <= '0;
                end
                DRAW: begin
                    tries <= tries_inc;
                    // Fold is safe: mask < 2*lim, so m - lim < lim.
                    if (hit) begin
                        value    <= m;
                        fallback <= 1'b0;
                    end else if (give_up) begin
                        value    <= m - lim_q;
                        fallback <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (state_q == DONE);
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_rng_range_sampler.sv
// Directed-vector bench for rng_range_sampler with hand-computed expectations.
module tb_rng_range_sampler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] rng_data = '0;
    logic        req = 1'b0;
    logic [3:0]  limit = '0;
    logic [3:0]  value;
    logic        valid, ack = 1'b0, busy, err, fallback;
    logic [7:0]  tries;

    int n_vec = 0;
    int n_bad = 0;

    rng_range_sampler #(.RNG_BITS(11), .OUT_W(4), .MAX_TRIES(8)) dut (
        .clk(clk), .rst_n(rst_n), .rng_data(rng_data), .req(req), .limit(limit),
        .value(value), .valid(valid), .ack(ack), .busy(busy), .err(err),
        .fallback(fallback), .tries(tries)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag, input logic [3:0] v, input logic [7:0] t,
                              input logic fb, input logic e);
        chk({tag, ".valid"}, valid, 1);
        chk({tag, ".value"}, value, v);
        chk({tag, ".tries"}, tries, t);
        chk({tag, ".fallback"}, fallback, fb);
        chk({tag, ".err"}, err, e);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack.valid_low", valid, 0);
        chk("ack.busy_low", busy, 0);
    endtask

    initial begin
        #2;
        chk("rst.valid", valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.value", value, 0);
        chk("rst.tries", tries, 0);
        chk("rst.err", err, 0);
        chk("rst.fallback", fallback, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // limit 10, first draw hits
        req = 1'b1; limit = 4'd10;
        tick();
        req = 1'b0; limit = 4'd0;
        chk("t1.busy", busy, 1);
        chk("t1.valid_early", valid, 0);
        rng_data = 11'h7F3;
        tick();
        chk_result("t1", 4'd3, 8'd1, 1'b0, 1'b0);
        do_ack();

        // limit 10, two rejects then hit
        req = 1'b1; limit = 4'd10;
        tick();
        req = 1'b0;
        rng_data = 11'h0FE;
        tick();
        chk("t2.valid_d1", valid, 0);
        chk("t2.tries_d1", tries, 1);
        rng_data = 11'h00C;
        tick();
        chk("t2.valid_d2", valid, 0);
        rng_data = 11'h2A7;
        tick();
        chk_result("t2", 4'd7, 8'd3, 1'b0, 1'b0);
        do_ack();

        // limit 5, mask 7, nibble 7 always rejected -> fold to 2 after 8 draws
        req = 1'b1; limit = 4'd5;
        tick();
        req = 1'b0;
        rng_data = 11'h00F;
        for (int i = 0; i < 7; i++) tick();
        chk("t3.valid_d7", valid, 0);
        chk("t3.tries_d7", tries, 7);
        tick();
        chk_result("t3", 4'd2, 8'd8, 1'b1, 1'b0);
        do_ack();

        // limit 0 -> immediate error result
        req = 1'b1; limit = 4'd0;
        tick();
        req = 1'b0;
        chk_result("t4", 4'd0, 8'd0, 1'b0, 1'b1);
        do_ack();

        // limit 1 -> mask 0, always value 0 on first draw
        req = 1'b1; limit = 4'd1;
        tick();
        req = 1'b0;
        rng_data = 11'h7FF;
        tick();
        chk_result("t5", 4'd0, 8'd1, 1'b0, 1'b0);
        do_ack();

        // limit 3, mask 3, nibble 2 hits; then hold with req toggling
        req = 1'b1; limit = 4'd3;
        tick();
        req = 1'b0;
        rng_data = 11'h002;
        tick();
        chk_result("t6", 4'd2, 8'd1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            req = ~req;
            limit = 4'(i);
            rng_data = 11'($urandom);
            tick();
            chk("t6.hold_valid", valid, 1);
            chk("t6.hold_value", value, 2);
        end
        req = 1'b1; ack = 1'b1; limit = 4'd4;
        tick();
        ack = 1'b0;
        chk("t6.ackreq_valid", valid, 0);
        chk("t6.ackreq_busy", busy, 0);
        tick();
        req = 1'b0;
        chk("t6.reaccept_busy", busy, 1);
        rng_data = 11'h001;
        tick();
        chk_result("t6b", 4'd1, 8'd1, 1'b0, 1'b0);
        do_ack();

        // reset mid-DRAW aborts
        req = 1'b1; limit = 4'd10;
        tick();
        req = 1'b0;
        rng_data = 11'h00F;
        tick();
        chk("t7.in_draw", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t7.rst_busy", busy, 0);
        chk("t7.rst_valid", valid, 0);
        chk("t7.rst_tries", tries, 0);
        chk("t7.rst_value", value, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t7.no_valid", valid, 0);
        end
        req = 1'b1; limit = 4'd6;
        tick();
        req = 1'b0;
        rng_data = 11'h005;
        tick();
        chk_result("t7", 4'd5, 8'd1, 1'b0, 1'b0);
        do_ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rng_range_sampler.md
RNG_RANGE_SAMPLER -- requirements
Module: rng_range_sampler

Interface
REQ-001 The block SHALL have parameters: RNG_BITS, default 11, width of the raw random word.
REQ-002 The block SHALL have parameters: OUT_W, default 4, width of the sampled value and the limit.
REQ-003 The block SHALL have parameters: MAX_TRIES, default 8, maximum number of draws before fallback; legal range 1..255.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port rng_data, input, RNG_BITS: free-running random word, new value every cycle, sampled only in DRAW.
REQ-007 Port req, input, 1: request for one sample; level, accepted only in IDLE.
REQ-008 Port limit, input, OUT_W: exclusive upper bound N; latched on request acceptance.
REQ-009 Port value, output, OUT_W: sampled result in [0, N-1].
REQ-010 Port valid, output, 1: value is held stable and valid.
REQ-011 Port ack, input, 1: consumer accepts value; effective only while valid=1.
REQ-012 Port busy, output, 1: high in DRAW and DONE.
REQ-013 Port err, output, 1: qualifies valid; high when the latched limit was 0.
REQ-014 Port fallback, output, 1: qualifies valid; high when the result came from the MAX_TRIES fallback path.
REQ-015 Port tries, output, 8: number of draws used for the current or last result.

Function
REQ-016 States SHALL be IDLE, DRAW and DONE, with IDLE as the reset state.
REQ-017 IDLE with req=1 and limit!=0 SHALL, on that edge, latch limit to lim_q, compute mask_q, clear tries, and enter DRAW.
REQ-018 mask_q SHALL be the smallest all-ones value of the form 2^k-1 that is >= lim_q-1; for lim_q=1, mask_q=0.
REQ-019 IDLE with req=1 and limit=0 SHALL enter DONE directly with value=0, err=1, fallback=0 and tries=0, so that valid=1 one cycle after acceptance.
REQ-020 On each DRAW cycle the block SHALL form m = rng_data[OUT_W-1:0] & mask_q and increment tries.
REQ-021 In DRAW, if m < lim_q, the block SHALL set value=m, fallback=0, and enter DONE.
REQ-022 In DRAW, if m >= lim_q and the incremented tries < MAX_TRIES, the block SHALL stay in DRAW and draw again on the next cycle.
REQ-023 In DRAW, if m >= lim_q and the incremented tries = MAX_TRIES, the block SHALL set value=m-lim_q and fallback=1, then enter DONE; this result is always < lim_q.
REQ-024 Latency from request acceptance to valid=1 SHALL be 1+d cycles, where d is the number of draws used (1..MAX_TRIES).
REQ-025 valid SHALL equal (state==DONE); value, err, fallback and tries SHALL be stable while valid=1.
REQ-026 In DONE with ack=1, the block SHALL return to IDLE; valid SHALL be low on the following cycle.
REQ-027 In DONE with ack=0, the block SHALL hold indefinitely.
REQ-028 req asserted in DRAW or DONE SHALL be ignored; limit changes after acceptance SHALL have no effect.
REQ-029 Simultaneous ack and req in DONE SHALL honor the ack only; the request is accepted no earlier than the next IDLE cycle.
REQ-030 ack outside DONE SHALL have no effect.
REQ-031 With a held req=1, a new request SHALL be accepted in the cycle after each return to IDLE; back-to-back throughput is one result per 3 or more cycles.
REQ-032 lim_q and mask_q SHALL be OUT_W bits wide, comparisons SHALL be unsigned, and tries SHALL saturate at MAX_TRIES.

Reset
REQ-033 rst_n low SHALL asynchronously force state=IDLE and value, valid, busy, err, fallback, tries, lim_q and mask_q to 0.
REQ-034 Reset asserted in DRAW or DONE SHALL abort the operation; no valid pulse SHALL follow release.
REQ-035 After reset release, the first request SHALL be accepted on the first clock edge at which req=1.

Verification
REQ-036 limit=10, rng_data low nibble=0x3 on the draw cycle -> mask_q=0xF, valid=1 two cycles after acceptance, value=3, tries=1, fallback=0.
REQ-037 limit=10, rng_data low nibbles 0xE, 0xC, then 0x7 -> tries=3, value=7, valid=1 four cycles after acceptance.
REQ-038 limit=5, MAX_TRIES=8, low nibble held at 0x7 -> mask_q=0x7; after 8 draws value=2, fallback=1, tries=8.
REQ-039 limit=0 -> valid=1 the next cycle with value=0, err=1; limit=1 -> value=0, tries=1.
REQ-040 ack held low for 20 cycles with req toggling -> valid and value stable, no new acceptance; ack and req high together -> IDLE, then re-accept one cycle later.
REQ-041 rst_n pulsed low mid-DRAW -> all outputs 0 immediately and no valid after release; a subsequent request completes normally.
